// File: rtl/flick_cond.sv
// Flick push-button conditioner: 2-FF synchroniser, press/release debounce, minimum-hold stretch.
// Optional auto-repeat pulses on flick_pls when FLICK_RPT_EN is defined.
`timescale 1ns/1ps
module flick_cond #(
  parameter int DB_CYC   = 4,
  parameter int HOLD_CYC = 8,
  parameter int RPT_CYC  = 16,
  parameter int CNT_W    = 8,
  parameter int FF_DLY   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flick_btn,
  output logic       flick,
  output logic       flick_pls,
  output logic [1:0] db_state
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] PRESS_DB = 2'b01;
  localparam logic [1:0] HELD     = 2'b10;
  localparam logic [1:0] REL_DB   = 2'b11;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(HOLD_CYC);

  // FF_DLY only exists for legacy gate-level flows; the registers here carry no delay.
  if (DB_CYC < 1 || HOLD_CYC < 1 || RPT_CYC < 2 || FF_DLY < 0 ||
      DB_CYC >= (1 << CNT_W) || HOLD_CYC >= (1 << CNT_W) || RPT_CYC >= (1 << CNT_W)) begin : g_bad_param
    $error("flick_cond: illegal parameter combination");
  end

  logic             sync_meta;
  logic             sync;
  logic [1:0]       state,    state_nx;
  logic [CNT_W-1:0] db_cnt,   db_cnt_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic             pls_nx;
`ifdef FLICK_RPT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_CYC - 1);
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nx;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx    = state;
    db_cnt_nx   = db_cnt;
    hold_cnt_nx = hold_cnt;
    pls_nx      = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          state_nx  = PRESS_DB;
          db_cnt_nx = '0;
        end
      end
      PRESS_DB: begin
        if (!sync) begin
          state_nx = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nx    = HELD;
          hold_cnt_nx = '0;
          pls_nx      = 1'b1;
        end else begin
          db_cnt_nx = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (hold_cnt != HOLD_MAX) hold_cnt_nx = hold_cnt + 1'b1;
        // Early releases are ignored until the minimum hold is reached.
        if (!sync && hold_cnt >= HOLD_LAST) begin
          state_nx  = REL_DB;
          db_cnt_nx = '0;
        end
      end
      default: begin // REL_DB
        if (sync) begin
          state_nx = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nx = IDLE;
        end else begin
          db_cnt_nx = db_cnt + 1'b1;
        end
      end
    endcase
`ifdef FLICK_RPT_EN
    rpt_cnt_nx = '0;
    if (state == HELD) begin
      rpt_cnt_nx = rpt_cnt;
      if (sync) begin
        if (rpt_cnt == RPT_LAST) begin
          rpt_cnt_nx = '0;
          pls_nx     = 1'b1;
        end else begin
          rpt_cnt_nx = rpt_cnt + 1'b1;
        end
      end
    end
`endif
  end

  // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync      <= 1'b0;
      state     <= IDLE;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      flick     <= 1'b0;
      flick_pls <= 1'b0;
`ifdef FLICK_RPT_EN
      rpt_cnt   <= '0;
`endif
    end else begin
      sync_meta <= flick_btn;
      sync      <= sync_meta;
      state     <= state_nx;
      db_cnt    <= db_cnt_nx;
      hold_cnt  <= hold_cnt_nx;
      // Registered from the next state so flick tracks HELD/REL_DB cycle-exactly.
      flick     <= (state_nx == HELD) || (state_nx == REL_DB);
      flick_pls <= pls_nx;
`ifdef FLICK_RPT_EN
      rpt_cnt   <= rpt_cnt_nx;
`endif
    end
  end

  assign db_state = state;

endmodule
